// File: rtl/icache_pkg.sv
// Shared types and defaults for the instruction-cache refill controller and its fetch-side users.
package icache_pkg;

  localparam int unsigned ADDR_W_DEF = 20;
  localparam int unsigned DATA_W_DEF = 32;

  // RISC-V "addi x0,x0,0", used by the fetch stage as a bubble instruction
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    CHECK,
    MEM_REQ,
    FILL
  } state_t;

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Fetch, cache and memory handshake bundle around icache_refill_ctrl.
interface icache_refill_ctrl_if
  import icache_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_ready;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic              bus_err;

  logic              ic_read_en;
  logic              ic_fetch;
  logic [ADDR_W-1:0] ic_read_addr;
  logic [ADDR_W-1:0] ic_write_addr;
  logic [DATA_W-1:0] ic_write_data;
  logic              ic_cache_miss;
  logic [DATA_W-1:0] ic_rdata;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic [15:0]       hit_cnt;
  logic [15:0]       miss_cnt;

  modport master (
    input  cpu_req, cpu_addr, ic_cache_miss, ic_rdata, mem_ack, mem_rdata,
    output cpu_ready, instr_valid, instr, bus_err,
           ic_read_en, ic_fetch, ic_read_addr, ic_write_addr, ic_write_data,
           mem_req, mem_addr, hit_cnt, miss_cnt
  );

  modport slave (
    output cpu_req, cpu_addr, ic_cache_miss, ic_rdata, mem_ack, mem_rdata,
    input  cpu_ready, instr_valid, instr, bus_err,
           ic_read_en, ic_fetch, ic_read_addr, ic_write_addr, ic_write_data,
           mem_req, mem_addr, hit_cnt, miss_cnt
  );

endinterface

// File: rtl/icache_refill_ctrl_sat_counter16.sv
// 16-bit event counter that sticks at 0xFFFF instead of wrapping.
module sat_counter16 (
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  output logic [15:0] count
);

  logic [15:0] r_count;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_count <= '0;
    end else if (en && (r_count != '1)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/icache_refill_ctrl.sv
// Single-request instruction-cache sequencer: lookup, hit return, or memory refill with timeout.
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned LOOKUP_LAT  = 2,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                 CLK_cpu,
  input  logic                 reset,
  icache_refill_ctrl_if.master bus
);

  localparam logic [7:0] LAT_LAST = 8'(LOOKUP_LAT - 1);
  localparam logic [7:0] TO_LAST  = 8'(MEM_TIMEOUT);

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              w_expired;
  logic              w_hit_en;
  logic              w_miss_en;
  logic              w_unused;

  assign w_expired = (r_state == MEM_REQ) && (r_cnt == TO_LAST);
  assign w_unused  = &{1'b0, bus.cpu_addr[1:0]};

  always_ff @(posedge CLK_cpu) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // One counter serves both the lookup wait and the memory timeout; it restarts on every state change.
  always_ff @(posedge CLK_cpu) begin
    if (reset) begin
      r_cnt  <= '0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_cnt <= (w_next != r_state) ? '0 : r_cnt + 8'd1;
      if ((r_state == IDLE) && bus.cpu_req) begin
        r_addr <= {bus.cpu_addr[ADDR_W-1:2], 2'b00};
      end
      if ((r_state == MEM_REQ) && bus.mem_ack) begin
        r_data <= bus.mem_rdata;
      end
    end
  end

  always_comb begin
    w_next            = r_state;
    w_hit_en          = 1'b0;
    w_miss_en         = 1'b0;
    bus.cpu_ready     = 1'b0;
    bus.instr_valid   = 1'b0;
    bus.instr         = '0;
    bus.bus_err       = 1'b0;
    bus.ic_read_en    = 1'b0;
    bus.ic_fetch      = 1'b0;
    bus.ic_read_addr  = '0;
    bus.ic_write_addr = '0;
    bus.ic_write_data = '0;
    bus.mem_req       = 1'b0;
    bus.mem_addr      = '0;

    // The cache indexes its tag update by write_addr, so both addresses track A outside IDLE.
    if (r_state != IDLE) begin
      bus.ic_read_addr  = r_addr;
      bus.ic_write_addr = r_addr;
    end

    case (r_state)
      IDLE: begin
        bus.cpu_ready = 1'b1;
        if (bus.cpu_req) w_next = LOOKUP;
      end
      LOOKUP: begin
        bus.ic_read_en = (r_cnt == '0);
        if (r_cnt == LAT_LAST) w_next = CHECK;
      end
      CHECK: begin
        if (bus.ic_cache_miss) begin
          w_miss_en = 1'b1;
          w_next    = MEM_REQ;
        end else begin
          w_hit_en        = 1'b1;
          bus.instr_valid = 1'b1;
          bus.instr       = bus.ic_rdata;
          w_next          = IDLE;
        end
      end
      MEM_REQ: begin
        if (!w_expired) begin
          bus.mem_req  = 1'b1;
          bus.mem_addr = r_addr;
        end
        // An ack on the expiry cycle still wins over the timeout.
        if (bus.mem_ack) begin
          w_next = FILL;
        end else if (w_expired) begin
          bus.bus_err = 1'b1;
          w_next      = IDLE;
        end
      end
      FILL: begin
        bus.ic_fetch      = 1'b1;
        bus.ic_write_data = r_data;
        bus.instr_valid   = 1'b1;
        bus.instr         = r_data;
        w_next            = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  sat_counter16 u_hit_cnt (
    .clk   (CLK_cpu),
    .clr   (reset),
    .en    (w_hit_en),
    .count (bus.hit_cnt)
  );

  sat_counter16 u_miss_cnt (
    .clk   (CLK_cpu),
    .clr   (reset),
    .en    (w_miss_en),
    .count (bus.miss_cnt)
  );

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Randomized bench for icache_refill_ctrl: the bench plays cache and memory, and predicts each fetch.
module tb_icache_refill_ctrl;
  import icache_pkg::*;

  localparam int unsigned AW  = 20;
  localparam int unsigned DW  = 32;
  localparam int          LAT = 2;
  localparam int          TO  = 255;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icache_refill_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  icache_refill_ctrl #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .LOOKUP_LAT  (LAT),
    .MEM_TIMEOUT (TO)
  ) dut (
    .CLK_cpu (clk),
    .reset   (rst),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Environment: cache array and memory contents seen by the DUT
  logic [DW-1:0] cmem [logic [AW-1:0]];
  logic [DW-1:0] mmem [logic [AW-1:0]];
  int cyc         = 0;
  int rd_cyc      = -1000;
  int mreq_cycles = 0;
  int mem_delay   = 0;
  bit mem_never   = 1'b0;
  bit inject_ack  = 1'b0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    if (mmem.exists(a)) return mmem[a];
    return {a[11:0], a} ^ 32'hC3A5_0F1E;
  endfunction

  // Cache data is only valid LAT cycles after the lookup strobe; junk otherwise.
  initial begin
    bus.ic_cache_miss = 1'b1;
    bus.ic_rdata      = '0;
    bus.mem_ack       = 1'b0;
    bus.mem_rdata     = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.ic_fetch) cmem[bus.ic_write_addr] = bus.ic_write_data;
      if (bus.ic_read_en) rd_cyc = cyc;
      if (cyc == rd_cyc + LAT) begin
        if (cmem.exists(bus.ic_read_addr)) begin
          bus.ic_cache_miss = 1'b0;
          bus.ic_rdata      = cmem[bus.ic_read_addr];
        end else begin
          bus.ic_cache_miss = 1'b1;
          bus.ic_rdata      = $urandom;
        end
      end else begin
        bus.ic_cache_miss = 1'($urandom_range(0, 1));
        bus.ic_rdata      = $urandom;
      end
      if (bus.mem_req) mreq_cycles++;
      else mreq_cycles = 0;
      bus.mem_ack   = (bus.mem_req && !mem_never && (mreq_cycles > mem_delay)) || inject_ack;
      bus.mem_rdata = bus.mem_ack ? mem_word(bus.mem_addr) : $urandom;
    end
  end

  typedef struct {
    int          c;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  ev_t vq[$];
  ev_t fq[$];
  int  bq[$];
  int  n_overlap = 0;
  int  n_memreq  = 0;

  always @(negedge clk) begin
    ev_t e;
    if (bus.ic_read_en && bus.ic_fetch) n_overlap++;
    if (bus.mem_req) n_memreq++;
    if (bus.bus_err) bq.push_back(cyc);
    if (bus.instr_valid) begin
      e.c = cyc; e.a = '0; e.d = bus.instr;
      vq.push_back(e);
    end
    if (bus.ic_fetch) begin
      e.c = cyc; e.a = 32'(bus.ic_write_addr); e.d = bus.ic_write_data;
      fq.push_back(e);
    end
  end

  // Reference model: what the cache holds and how many hits/misses have been counted
  logic [DW-1:0] mcache [logic [AW-1:0]];
  int unsigned   m_hits = 0;
  int unsigned   m_miss = 0;

  task automatic model_step(input logic [AW-1:0] aa, input int delay, input bit never,
                            output bit hit, output logic [31:0] d, output int off);
    hit = mcache.exists(aa);
    if (hit) begin
      d   = mcache[aa];
      off = LAT + 1;
      if (m_hits < 32'hFFFF) m_hits++;
    end else begin
      d = mem_word(aa);
      if (m_miss < 32'hFFFF) m_miss++;
      if (never) begin
        off = LAT + 2 + TO;
      end else begin
        off = LAT + 3 + delay;
        mcache[aa] = d;
      end
    end
  endtask

  task automatic clear_events();
    vq.delete(); fq.delete(); bq.delete();
  endtask

  task automatic issue(input logic [AW-1:0] a, output int acc);
    acc = -1;
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = a;
    for (int n = 0; n < 1000; n++) begin
      if (bus.cpu_ready) begin
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.cpu_req  = 1'b0;
    bus.cpu_addr = AW'($urandom);
    if (acc < 0) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic txn(input logic [AW-1:0] a, input int delay, input bit never);
    logic [AW-1:0] aa;
    bit            hit;
    bit            seen;
    logic [31:0]   d;
    int            off;
    int            acc;
    int            mr0;
    aa = {a[AW-1:2], 2'b00};
    model_step(aa, delay, never, hit, d, off);
    mem_delay = delay;
    mem_never = never;
    clear_events();
    mr0 = n_memreq;
    issue(a, acc);
    seen = 1'b0;
    for (int n = 0; n < 400 + delay; n++) begin
      @(posedge clk);
      if (vq.size() != 0 || bq.size() != 0) begin
        seen = 1'b1;
        break;
      end
    end
    @(negedge clk);
    if (!seen) begin
      check("outcome_timeout", 32'd0, 32'd1);
    end else if (never && !hit) begin
      check("berr_count", bq.size(), 1);
      check("berr_cycle", bq[0], acc + off);
      check("berr_no_valid", vq.size(), 0);
      check("berr_no_fill", fq.size(), 0);
      check("ready_after_berr", bus.cpu_ready, 1);
    end else begin
      check("valid_count", vq.size(), 1);
      check("valid_cycle", vq[0].c, acc + off);
      check("instr", vq[0].d, d);
      check("no_berr", bq.size(), 0);
      if (hit) begin
        check("hit_no_fill", fq.size(), 0);
        check("hit_no_memreq", n_memreq - mr0, 0);
      end else begin
        check("fill_count", fq.size(), 1);
        check("fill_cycle", fq[0].c, vq[0].c);
        check("fill_addr", fq[0].a, 32'(aa));
        check("fill_data", fq[0].d, d);
      end
    end
    @(negedge clk);
    check("hit_cnt", bus.hit_cnt, m_hits);
    check("miss_cnt", bus.miss_cnt, m_miss);
  endtask

  initial begin
    int            acc;
    int            idx;
    bit            seen;
    logic [AW-1:0] ba   [3];
    int            bacc [3];
    bit            bh   [3];
    logic [31:0]   bd   [3];
    int            bo   [3];
    logic [AW-1:0] pool [8];

    rst          = 1'b1;
    bus.cpu_req  = 1'b0;
    bus.cpu_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_cpu_ready", bus.cpu_ready, 1);
    check("rst_instr_valid", bus.instr_valid, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_read_en", bus.ic_read_en, 0);
    check("rst_fetch", bus.ic_fetch, 0);
    check("rst_bus_err", bus.bus_err, 0);
    check("rst_read_addr", 32'(bus.ic_read_addr), 0);
    check("rst_write_addr", 32'(bus.ic_write_addr), 0);
    check("rst_hit_cnt", bus.hit_cnt, 0);
    check("rst_miss_cnt", bus.miss_cnt, 0);
    rst = 1'b0;

    // Hit on a preloaded line
    cmem[20'h00100]   = 32'hDEAD_BEEF;
    mcache[20'h00100] = 32'hDEAD_BEEF;
    txn(20'h00100, 0, 1'b0);

    // Miss with a delayed ack, then the same line hits
    mmem[20'h00204] = 32'h1234_5678;
    txn(20'h00204, 5, 1'b0);
    txn(20'h00204, 0, 1'b0);

    // Timeout, then a stray ack while idle
    txn(20'h00300, 0, 1'b1);
    clear_events();
    @(negedge clk); inject_ack = 1'b1;
    @(negedge clk); inject_ack = 1'b0;
    repeat (4) @(negedge clk);
    check("late_ack_no_valid", vq.size(), 0);
    check("late_ack_no_fill", fq.size(), 0);
    check("late_ack_idle", bus.cpu_ready, 1);

    // Reset two cycles into a memory wait
    clear_events();
    mem_never = 1'b1;
    issue(20'h00408, acc);
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.mem_req) begin
        seen = 1'b1;
        break;
      end
    end
    check("rst_reach_memreq", seen, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_mem_req", bus.mem_req, 0);
    check("midrst_idle", bus.cpu_ready, 1);
    check("midrst_fetch", bus.ic_fetch, 0);
    check("midrst_miss_cnt", bus.miss_cnt, 0);
    rst    = 1'b0;
    m_hits = 0;
    m_miss = 0;
    @(negedge clk); inject_ack = 1'b1;
    @(negedge clk); inject_ack = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_no_fill", fq.size(), 0);
    check("midrst_no_valid", vq.size(), 0);
    mem_never = 1'b0;

    // Back-to-back with cpu_req held: hit, miss, hit
    ba[0] = 20'h00101; ba[1] = 20'h00500; ba[2] = 20'h00206;
    mem_delay = 3;
    clear_events();
    for (int i = 0; i < 3; i++) model_step({ba[i][AW-1:2], 2'b00}, 3, 1'b0, bh[i], bd[i], bo[i]);
    idx = 0;
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = ba[0];
    for (int n = 0; n < 200 && idx < 3; n++) begin
      if (bus.cpu_ready) begin
        bacc[idx] = cyc;
        idx++;
        @(negedge clk);
        if (idx < 3) bus.cpu_addr = ba[idx];
        else bus.cpu_req = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    check("b2b_accepts", idx, 3);
    for (int n = 0; n < 100; n++) begin
      if (vq.size() >= 3) break;
      @(posedge clk);
    end
    repeat (2) @(negedge clk);
    check("b2b_valid_count", vq.size(), 3);
    for (int i = 0; i < 3 && i < vq.size(); i++) begin
      check("b2b_instr", vq[i].d, bd[i]);
      check("b2b_cycle", vq[i].c, bacc[i] + bo[i]);
    end
    check("b2b_fill_count", fq.size(), 1);
    check("b2b_hit_cnt", bus.hit_cnt, m_hits);

    // Saturation from a preset near the top
    @(negedge clk);
    force dut.u_hit_cnt.r_count = 16'hFFFE;
    #1 release dut.u_hit_cnt.r_count;
    m_hits = 32'hFFFE;
    check("sat_preset", bus.hit_cnt, 16'hFFFE);
    repeat (3) txn(20'h00100, 0, 1'b0);

    // Random traffic over a small address pool
    for (int i = 0; i < 8; i++) pool[i] = AW'($urandom);
    for (int i = 0; i < 40; i++) begin
      txn(pool[$urandom_range(0, 7)] | AW'($urandom_range(0, 3)),
          int'($urandom_range(0, 6)), ($urandom_range(0, 11) == 0));
    end

    check("read_en_fetch_overlap", n_overlap, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
